// File: rtl/ebus_responder.sv
// EBUS device responder: decodes CONO/CONI/DATAO/DATAI for one controller-select code,
// paces the transfer acknowledge and drives the priority-interrupt request.
module ebus_responder #(
   parameter logic [6:0] DEV_CS     = 7'o200,
   parameter int         XFER_DELAY = 2
) (
   input  logic        clk,
   input  logic        CROBAR_N,
   input  logic [0:6]  EBUS_CS,
   input  logic [0:2]  EBUS_FUNC,
   input  logic        EBUS_DEMAND,
   input  logic [0:35] EBUS_DATA_IN,
   output logic        EBUS_XFER,
   output logic        DRV_DRIVING,
   output logic [0:35] DRV_DATA,
   output logic [0:35] DATAO_DATA,
   output logic        DATAO_STB,
   input  logic [0:35] DATAI_DATA,
   input  logic [0:31] DEV_STATUS,
   input  logic        DEV_IRQ,
   output logic [1:7]  PI_REQ
);

   typedef enum logic [1:0] {IDLE, WAIT, XFER} state_e;
   typedef enum logic [1:0] {F_CONO = 2'd0, F_CONI = 2'd1, F_DATAO = 2'd2, F_DATAI = 2'd3} func_e;

   localparam logic [3:0] CNT_LOAD = 4'(XFER_DELAY - 1);

   state_e      state_q;
   func_e       func_q;
   logic [3:0]  cnt_q;
   logic [0:35] data_q;
   logic [0:35] dout_q;
   logic [0:2]  level_q;
   logic [1:7]  pi_q, pi_d;
   logic        xfer_q, drv_q, stb_q, flag_q, flag_d;
   logic        select, wr_edge, cono_clr;

   // FUNC codes 4-7 have the MSB set and never select the device.
   assign select   = EBUS_DEMAND && (EBUS_CS == DEV_CS) && !EBUS_FUNC[0];
   assign wr_edge  = (state_q == WAIT) && EBUS_DEMAND && (cnt_q == 4'd0);
   assign cono_clr = wr_edge && (func_q == F_CONO) && data_q[32];

   // A same-cycle attention pulse overrides a CONO clear.
   assign flag_d = DEV_IRQ | (flag_q & ~cono_clr);

   always_comb begin
      pi_d = '0;
      for (int n = 1; n <= 7; n++)
         pi_d[n] = flag_q && (level_q == 3'(n));
   end

   always_ff @(posedge clk or negedge CROBAR_N) begin
      if (!CROBAR_N) begin
         state_q <= IDLE;
         func_q  <= F_CONO;
         cnt_q   <= '0;
         data_q  <= '0;
         dout_q  <= '0;
         level_q <= '0;
         xfer_q  <= 1'b0;
         drv_q   <= 1'b0;
         stb_q   <= 1'b0;
         flag_q  <= 1'b0;
         pi_q    <= '0;
      end else begin
         stb_q  <= 1'b0;
         flag_q <= flag_d;
         pi_q   <= pi_d;
         case (state_q)
            IDLE: if (select) begin
               state_q <= WAIT;
               cnt_q   <= CNT_LOAD;
               func_q  <= func_e'(EBUS_FUNC[1:2]);
               data_q  <= EBUS_DATA_IN;
               drv_q   <= EBUS_FUNC[2];
            end
            WAIT: begin
               if (!EBUS_DEMAND) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  drv_q   <= 1'b0;
               end else if (cnt_q == 4'd0) begin
                  state_q <= XFER;
                  if (func_q == F_DATAO) begin
                     dout_q <= data_q;
                     stb_q  <= 1'b1;
                  end
                  if (func_q == F_CONO)
                     level_q <= data_q[33:35];
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            XFER: begin
               if (!EBUS_DEMAND) begin
                  state_q <= IDLE;
                  xfer_q  <= 1'b0;
                  drv_q   <= 1'b0;
               end else begin
                  xfer_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign EBUS_XFER   = xfer_q;
   assign DRV_DRIVING = drv_q;
   assign DATAO_DATA  = dout_q;
   assign DATAO_STB   = stb_q;
   assign PI_REQ      = pi_q;

   // Read data is live from its source while driving, forced to zero otherwise.
   assign DRV_DATA = !drv_q ? '0 :
                     (func_q == F_CONI) ? {DEV_STATUS, flag_q, level_q} : DATAI_DATA;

endmodule

// File: tb/tb_ebus_responder.sv
// Bench for ebus_responder: fixed vector table, hand-written corner sequences and
// random transactions checked against a transaction-level timing model.
module tb_ebus_responder;

   localparam int         D  = 2;
   localparam logic [6:0] CS = 7'o200;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [0:6]  cs;
   logic [0:2]  func;
   logic        dem;
   logic [0:35] din;
   logic        xfer, drv, stb, irq;
   logic [0:35] drv_data, dout, datai;
   logic [0:31] status;
   logic [1:7]  pi;

   ebus_responder #(.DEV_CS(CS), .XFER_DELAY(D)) dut (
      .clk(clk), .CROBAR_N(rst_n), .EBUS_CS(cs), .EBUS_FUNC(func), .EBUS_DEMAND(dem),
      .EBUS_DATA_IN(din), .EBUS_XFER(xfer), .DRV_DRIVING(drv), .DRV_DATA(drv_data),
      .DATAO_DATA(dout), .DATAO_STB(stb), .DATAI_DATA(datai), .DEV_STATUS(status),
      .DEV_IRQ(irq), .PI_REQ(pi)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [35:0] m_dout;
   logic        m_flag;
   logic [2:0]  m_level;

   typedef struct {
      logic [2:0]  f;
      logic [6:0]  c;
      logic [35:0] d;
      int          h;
      int          rise;
      int          xcnt;
      int          stbs;
      int          drvs;
      logic [35:0] dout;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   function automatic logic [6:0] pi_exp();
      pi_exp = (m_flag && m_level != 3'd0) ? 7'(1 << (7 - m_level)) : 7'd0;
   endfunction

   // One transaction: demand held for h sampled edges starting at the latch edge (k=0).
   // Per-cycle outputs are predicted from the timing rules; summaries are returned.
   task automatic run_txn(input logic [2:0] f, input logic [6:0] c, input logic [35:0] d,
                          input int h, input int irq_at, input bit churn,
                          output int rise, output int xcnt, output int stbs, output int drvs);
      bit sel, rd, wr, ex, edrv, es;
      logic [35:0] exp_dd;
      sel  = (c == CS) && (f < 3'd4);
      rd   = sel && (f == 3'd1 || f == 3'd3);
      wr   = sel && (h >= D + 1);
      rise = -1; xcnt = 0; stbs = 0; drvs = 0;
      cs = c; func = f; din = d; dem = 1'b1;
      datai = d; status = d[35:4];
      if (irq_at == 0) irq = 1'b1;
      for (int k = 0; k <= h + 1; k++) begin
         @(posedge clk); #1;
         if (wr && k == D) begin
            if (f == 3'd2) m_dout = d;
            if (f == 3'd0) begin
               m_level = d[2:0];
               if (d[3]) m_flag = 1'b0;
            end
         end
         if (irq_at == k) m_flag = 1'b1;
         ex   = sel && (k >= D + 1) && (k <= h - 1);
         edrv = rd && (k <= h - 1);
         es   = wr && (f == 3'd2) && (k == D);
         check($sformatf("ctl k=%0d", k), {61'd0, xfer, drv, stb}, {61'd0, ex, edrv, es});
         exp_dd = !edrv ? 36'd0 : (f == 3'd1) ? {status, m_flag, m_level} : datai;
         check($sformatf("drv_data k=%0d", k), drv_data, exp_dd);
         if (xfer) begin xcnt++; if (rise < 0) rise = k; end
         if (stb) stbs++;
         if (drv) drvs++;
         if (churn) begin
            datai  = 36'({$urandom, $urandom});
            status = $urandom;
         end
         if (k == h - 1) dem = 1'b0;
         if (k + 1 == irq_at) irq = 1'b1;
         if (k == irq_at) irq = 1'b0;
      end
   endtask

   task automatic settle_check(input string tag);
      tick(); tick();
      check({tag, " pi"}, pi, pi_exp());
      check({tag, " dout"}, dout, m_dout);
   endtask

   task automatic irq_pulse();
      irq = 1'b1; tick(); irq = 1'b0;
      m_flag = 1'b1;
   endtask

   initial begin
      vec_t tbl[6];
      int rise, xcnt, stbs, drvs;
      bit seen;
      logic [2:0] f;
      logic [6:0] c;

      tbl[0] = '{3'd2, 7'o200, 36'o123456701234, 5,  3, 2, 1, 0, 36'o123456701234};
      tbl[1] = '{3'd3, 7'o201, 36'o777000777000, 5, -1, 0, 0, 0, 36'o123456701234};
      tbl[2] = '{3'd3, 7'o200, 36'o777000777000, 5,  3, 2, 0, 5, 36'o123456701234};
      tbl[3] = '{3'd2, 7'o200, 36'o000000000007, 2, -1, 0, 0, 0, 36'o123456701234};
      tbl[4] = '{3'd5, 7'o200, 36'o000000000007, 4, -1, 0, 0, 0, 36'o123456701234};
      tbl[5] = '{3'd0, 7'o200, 36'o000000000005, 4,  3, 1, 0, 0, 36'o123456701234};

      rst_n = 1'b0; cs = '0; func = '0; dem = 1'b0; din = '0; datai = '0; status = '0; irq = 1'b0;
      m_dout = '0; m_flag = 1'b0; m_level = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst xfer/drv/stb", {xfer, drv, stb}, 3'b000);
      check("rst drv_data", drv_data, 36'd0);
      check("rst dout", dout, 36'd0);
      check("rst pi", pi, 7'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_txn(tbl[i].f, tbl[i].c, tbl[i].d, tbl[i].h, -1, 1'b0, rise, xcnt, stbs, drvs);
         check($sformatf("vec%0d rise", i), rise, tbl[i].rise);
         check($sformatf("vec%0d xcnt", i), xcnt, tbl[i].xcnt);
         check($sformatf("vec%0d stbs", i), stbs, tbl[i].stbs);
         check($sformatf("vec%0d drvs", i), drvs, tbl[i].drvs);
         check($sformatf("vec%0d dout", i), dout, tbl[i].dout);
      end

      // Attention pulse after CONO level 5: PI_REQ lags the flag by one cycle.
      irq = 1'b1; tick(); irq = 1'b0;
      check("pi lag", pi, 7'b0000000);
      tick();
      check("pi level5", pi, 7'b0000100);
      m_flag = 1'b1;

      run_txn(3'd1, CS, 36'o525252525252, 4, -1, 1'b0, rise, xcnt, stbs, drvs);
      check("coni drvs", drvs, 4);
      check("coni rise", rise, 3);

      // CONO with clear bit, then clear coinciding with an attention pulse.
      run_txn(3'd0, CS, 36'o000000000015, 4, -1, 1'b0, rise, xcnt, stbs, drvs);
      settle_check("clr");
      check("clr pi", pi, 7'd0);
      irq_pulse();
      run_txn(3'd0, CS, 36'o000000000015, 4, D, 1'b0, rise, xcnt, stbs, drvs);
      settle_check("clr+irq");
      check("clr+irq flag", dut.flag_q, 1'b1);
      check("clr+irq pi", pi, 7'b0000100);

      // Reset mid-XFER of a CONI, demand held high across reset.
      cs = CS; func = 3'd1; dem = 1'b1; status = 32'hA5A55A5A; seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(posedge clk); #1;
         seen = xfer;
      end
      check("rst xfer seen", seen, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst xfer/drv", {xfer, drv}, 2'b00);
      check("midrst pi", pi, 7'd0);
      check("midrst level", dut.level_q, 3'd0);
      check("midrst drv_data", drv_data, 36'd0);
      check("midrst dout", dout, 36'd0);
      m_dout = '0; m_flag = 1'b0; m_level = '0;
      #3 rst_n = 1'b1;
      tick();
      check("post-rst accept", drv, 1'b1);
      check("post-rst coni data", drv_data, {32'hA5A55A5A, 4'b0000});
      dem = 1'b0;
      tick(); tick();
      check("post-rst idle", {xfer, drv}, 2'b00);

      for (int t = 0; t < 40; t++) begin
         f = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         c = ($urandom_range(0, 4) == 0) ? 7'($urandom) : CS;
         run_txn(f, c, 36'({$urandom, $urandom}), $urandom_range(1, 7), -1, 1'b1,
                 rise, xcnt, stbs, drvs);
         if ($urandom_range(0, 2) == 0) irq_pulse();
         settle_check($sformatf("rnd%0d", t));
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/ebus_responder.md
EBUS_RESPONDER -- requirements
Module: ebus_responder

Interface
REQ-001 Parameter DEV_CS, default 7'o200: EBUS controller-select code this device answers to.
REQ-002 Parameter XFER_DELAY, default 2: cycles from select to EBUS_XFER assertion; legal range 1..15.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 CROBAR_N  in  1  asynchronous, active-low reset.
REQ-005 EBUS_CS  in  [0:6]  controller select from the EBOX.
REQ-006 EBUS_FUNC  in  [0:2]  function: 0 CONO, 1 CONI, 2 DATAO, 3 DATAI; 4-7 ignored.
REQ-007 EBUS_DEMAND  in  1  EBOX request strobe.
REQ-008 EBUS_DATA_IN  in  [0:35]  muxed EBUS data, sampled for CONO and DATAO.
REQ-009 EBUS_XFER  out  1  device transfer acknowledge.
REQ-010 DRV_DRIVING  out  1  request to the top-level EBUS mux to select this device's data.
REQ-011 DRV_DATA  out  [0:35]  data offered to the EBUS mux; zero whenever DRV_DRIVING is 0.
REQ-012 DATAO_DATA  out  [0:35]  last word written by DATAO.
REQ-013 DATAO_STB  out  1  one-cycle pulse when DATAO_DATA is updated.
REQ-014 DATAI_DATA  in  [0:35]  device word returned by DATAI.
REQ-015 DEV_STATUS  in  [0:31]  device status returned by CONI.
REQ-016 DEV_IRQ  in  1  device attention pulse; sets the attention flag.
REQ-017 PI_REQ  out  [1:7]  one-hot priority-interrupt request.

Function
REQ-018 States: IDLE, WAIT, XFER.
REQ-019 The select condition is EBUS_DEMAND=1, EBUS_CS=DEV_CS, and EBUS_FUNC in 0..3.
- IDLE moves to WAIT on the select condition.
- On that edge, FUNC and EBUS_DATA_IN are latched and the delay counter is loaded with XFER_DELAY-1.
REQ-020 WAIT decrements the counter each cycle.
- At counter zero it enters XFER and asserts EBUS_XFER on the following cycle.
- Total latency from the latch edge to EBUS_XFER=1 is XFER_DELAY+1 cycles.
REQ-021 XFER holds EBUS_XFER=1 until EBUS_DEMAND is sampled 0, then returns to IDLE with EBUS_XFER=0 in the same edge.
REQ-022 EBUS_DEMAND falling while in WAIT is an abort.
- Return to IDLE.
- No register update, no DATAO_STB, EBUS_XFER is never asserted.
REQ-023 CONO writes take effect on the WAIT->XFER edge; DATAO writes take effect on the same edge.
- CONO bits [33:35] are loaded into the PI level register.
- CONO bit 32 = 1 clears the attention flag.
- DATAO loads DATAO_DATA from the latched word and pulses DATAO_STB for exactly one cycle.
REQ-024 For CONI and DATAI, DRV_DRIVING=1 from the cycle after the latch edge through the last XFER cycle.
- CONI: DRV_DATA = {DEV_STATUS[0:31], flag, level[0:2]}.
- DATAI: DRV_DATA = DATAI_DATA.
- DRV_DATA is the live value of its source, not a snapshot.
REQ-025 DRV_DRIVING is never 1 for CONO, DATAO, ignored functions, or a non-matching CS.
REQ-026 DEV_IRQ=1 sets the attention flag; when DEV_IRQ and a CONO clear occur in the same cycle, the set wins.
REQ-027 PI_REQ[n]=1 exactly when flag=1 and level=n; level 0 gives PI_REQ=0.
- PI_REQ is registered from flag and level, so it lags either of them by one cycle.
REQ-028 A new select condition is not accepted until the FSM has returned to IDLE; back-to-back transactions need at least one IDLE cycle with EBUS_DEMAND=0.

Reset
REQ-029 CROBAR_N=0 asynchronously forces all of the following, regardless of state, including mid-transaction:
- state IDLE, counter 0;
- EBUS_XFER=0, DRV_DRIVING=0, DRV_DATA=0, DATAO_STB=0;
- DATAO_DATA=0, flag=0, level=0, PI_REQ=0.
REQ-030 After CROBAR_N deasserts, the first select condition is accepted on the next rising edge.
- A DEMAND that was already high throughout reset also counts as a select condition.

Verification
REQ-031 DATAO, CS=7'o200, data 36'o123456701234, XFER_DELAY=2.
- EBUS_XFER rises 3 cycles after the latch edge.
- DATAO_DATA=36'o123456701234 with a single DATAO_STB pulse.
- EBUS_XFER falls in the same edge where DEMAND is sampled 0.
REQ-032 CONO with data 36'o000000000005, then DEV_IRQ pulse.
- level=5; PI_REQ=7'b0000100 (only PI_REQ[5] set) one cycle after the flag sets.
- CONI then returns bits [32:35]=4'b1101 with DRV_DRIVING high through XFER.
REQ-033 DATAI with DATAI_DATA=36'o777000777000 and CS=7'o201.
- No response: EBUS_XFER and DRV_DRIVING stay 0.
- Repeat with CS=7'o200: DRV_DATA=36'o777000777000 while DRV_DRIVING=1.
REQ-034 DATAO with DEMAND dropped during WAIT: FSM returns to IDLE, DATAO_DATA unchanged, no DATAO_STB, EBUS_XFER never 1.
REQ-035 CONO with bit 32=1 issued on the same cycle as DEV_IRQ=1: flag remains 1.
REQ-036 CROBAR_N pulsed low while in XFER during a CONI: EBUS_XFER, DRV_DRIVING, PI_REQ and level all read 0 before the next clk edge.
